// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the traffic-light controller and the lamp drivers.
// It registers the lamp commands, catches conflicting or malformed patterns and bad phase sequences, and on a fault drives flashing all-red.
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW    = 3,
    parameter int FAULT_PERSIST = 2,
    parameter int FLASH_HALF    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ns_red,
    input  logic       ns_yellow,
    input  logic       ns_green,
    input  logic       ew_red,
    input  logic       ew_yellow,
    input  logic       ew_green,
    input  logic       clear,
    output logic       ns_red_o,
    output logic       ns_yellow_o,
    output logic       ns_green_o,
    output logic       ew_red_o,
    output logic       ew_yellow_o,
    output logic       ew_green_o,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int YW = $clog2(MIN_YELLOW + 2);
    localparam int PW = (FAULT_PERSIST < 2) ? 1 : $clog2(FAULT_PERSIST + 1);
    localparam int FW = (FLASH_HALF < 2) ? 1 : $clog2(FLASH_HALF + 1);

    localparam logic [YW-1:0] MIN_Y        = YW'(MIN_YELLOW);
    localparam logic [PW-1:0] PERSIST_LAST = PW'((FAULT_PERSIST > 1) ? FAULT_PERSIST - 1 : 0);
    localparam logic [FW-1:0] FLASH_LAST   = FW'((FLASH_HALF > 1) ? FLASH_HALF - 1 : 0);

    localparam logic [1:0] ST_MONITOR = 2'd0;
    localparam logic [1:0] ST_SUSPECT = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    localparam logic [1:0] PH_R = 2'd0;
    localparam logic [1:0] PH_Y = 2'd1;
    localparam logic [1:0] PH_G = 2'd2;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_CONFLICT = 3'd1;
    localparam logic [2:0] CODE_LAMP     = 3'd2;
    localparam logic [2:0] CODE_SEQ      = 3'd3;
    localparam logic [2:0] CODE_SHORT_Y  = 3'd4;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic          prev_valid;
    logic [1:0]    ns_prev;
    logic [1:0]    ew_prev;
    logic [YW-1:0] ns_ycnt;
    logic [YW-1:0] ew_ycnt;
    logic [PW-1:0] persist;
    logic [PW-1:0] persist_next;
    logic [FW-1:0] flash_cnt;
    logic [FW-1:0] flash_cnt_next;
    logic          flash_on;
    logic          flash_on_next;
    logic [2:0]    code_next;

    logic          conflict;
    logic          lamp;
    logic          pattern_bad;
    logic          ns_onehot;
    logic          ew_onehot;
    logic [1:0]    ns_ph;
    logic [1:0]    ew_ph;
    logic          seq_err;
    logic          short_err;
    logic [2:0]    pat_code;
    logic [2:0]    seq_code;
    logic          update_hist;
    logic          recover;
    logic [YW-1:0] ns_ycnt_next;
    logic [YW-1:0] ew_ycnt_next;

    function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
        logic ok;
        case (prev)
            PH_R:    ok = (cur == PH_R) || (cur == PH_G);
            PH_Y:    ok = (cur == PH_Y) || (cur == PH_R);
            PH_G:    ok = (cur == PH_G) || (cur == PH_Y);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pattern classification; the phase decode is only meaningful when both directions are one-hot.
    always_comb begin
        conflict    = (ns_green | ns_yellow) & (ew_green | ew_yellow);
        ns_onehot   = (ns_red + ns_yellow + ns_green) == 2'd1;
        ew_onehot   = (ew_red + ew_yellow + ew_green) == 2'd1;
        lamp        = ~conflict & (~ns_onehot | ~ew_onehot);
        pattern_bad = conflict | lamp;

        ns_ph = ns_green ? PH_G : (ns_yellow ? PH_Y : PH_R);
        ew_ph = ew_green ? PH_G : (ew_yellow ? PH_Y : PH_R);

        seq_err = prev_valid & ~pattern_bad &
                  (~legal_step(ns_prev, ns_ph) | ~legal_step(ew_prev, ew_ph));
        short_err = prev_valid & ~pattern_bad &
                    (((ns_prev == PH_Y) && (ns_ph == PH_R) && (ns_ycnt < MIN_Y)) ||
                     ((ew_prev == PH_Y) && (ew_ph == PH_R) && (ew_ycnt < MIN_Y)));

        pat_code = conflict ? CODE_CONFLICT : (lamp ? CODE_LAMP : CODE_NONE);
        seq_code = seq_err ? CODE_SEQ : (short_err ? CODE_SHORT_Y : CODE_NONE);

        ns_ycnt_next = (ns_ph == PH_Y) ? ((ns_ycnt < MIN_Y) ? ns_ycnt + 1'b1 : ns_ycnt) : '0;
        ew_ycnt_next = (ew_ph == PH_Y) ? ((ew_ycnt < MIN_Y) ? ew_ycnt + 1'b1 : ew_ycnt) : '0;
    end

    // State transitions; history only advances on a cycle that is fully legal.
    always_comb begin
        next_state   = state;
        persist_next = '0;
        code_next    = fault_code;
        update_hist  = 1'b0;
        recover      = 1'b0;
        case (state)
            ST_MONITOR: begin
                if (pattern_bad) begin
                    if (FAULT_PERSIST <= 1) begin
                        next_state = ST_FAULT;
                        code_next  = pat_code;
                    end else begin
                        next_state   = ST_SUSPECT;
                        persist_next = PW'(1);
                    end
                end else if (seq_code != CODE_NONE) begin
                    next_state = ST_FAULT;
                    code_next  = seq_code;
                end else begin
                    update_hist = 1'b1;
                end
            end
            ST_SUSPECT: begin
                if (pattern_bad) begin
                    if (persist >= PERSIST_LAST) begin
                        next_state = ST_FAULT;
                        code_next  = pat_code;
                    end else begin
                        persist_next = persist + 1'b1;
                    end
                end else if (seq_code != CODE_NONE) begin
                    next_state = ST_FAULT;
                    code_next  = seq_code;
                end else begin
                    next_state  = ST_MONITOR;
                    update_hist = 1'b1;
                end
            end
            ST_FAULT: begin
                if (clear && !pattern_bad) begin
                    next_state = ST_MONITOR;
                    code_next  = CODE_NONE;
                    recover    = 1'b1;
                end
            end
            default: begin
                next_state = ST_MONITOR;
                code_next  = CODE_NONE;
            end
        endcase
    end

    // Flash timing restarts with the reds lit on every entry into FAULT.
    always_comb begin
        flash_cnt_next = '0;
        flash_on_next  = 1'b1;
        if (next_state == ST_FAULT && state == ST_FAULT) begin
            if (flash_cnt >= FLASH_LAST) begin
                flash_cnt_next = '0;
                flash_on_next  = ~flash_on;
            end else begin
                flash_cnt_next = flash_cnt + 1'b1;
                flash_on_next  = flash_on;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_MONITOR;
            persist    <= '0;
            flash_cnt  <= '0;
            flash_on   <= 1'b1;
            fault_code <= CODE_NONE;
            fault      <= 1'b0;
        end else begin
            state      <= next_state;
            persist    <= persist_next;
            flash_cnt  <= flash_cnt_next;
            flash_on   <= flash_on_next;
            fault_code <= code_next;
            fault      <= (next_state == ST_FAULT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            ns_prev    <= PH_R;
            ew_prev    <= PH_R;
            ns_ycnt    <= '0;
            ew_ycnt    <= '0;
        end else if (recover) begin
            prev_valid <= 1'b0;
            ns_ycnt    <= '0;
            ew_ycnt    <= '0;
        end else if (update_hist) begin
            prev_valid <= 1'b1;
            ns_prev    <= ns_ph;
            ew_prev    <= ew_ph;
            ns_ycnt    <= ns_ycnt_next;
            ew_ycnt    <= ew_ycnt_next;
        end
    end

    // Lamp drive follows the state being entered, so nothing reaches the lamps combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ns_red_o    <= 1'b1;
            ns_yellow_o <= 1'b0;
            ns_green_o  <= 1'b0;
            ew_red_o    <= 1'b1;
            ew_yellow_o <= 1'b0;
            ew_green_o  <= 1'b0;
        end else begin
            case (next_state)
                ST_MONITOR: begin
                    ns_red_o    <= ns_red;
                    ns_yellow_o <= ns_yellow;
                    ns_green_o  <= ns_green;
                    ew_red_o    <= ew_red;
                    ew_yellow_o <= ew_yellow;
                    ew_green_o  <= ew_green;
                end
                ST_FAULT: begin
                    ns_red_o    <= flash_on_next;
                    ns_yellow_o <= 1'b0;
                    ns_green_o  <= 1'b0;
                    ew_red_o    <= flash_on_next;
                    ew_yellow_o <= 1'b0;
                    ew_green_o  <= 1'b0;
                end
                default: begin
                    ns_red_o    <= 1'b1;
                    ns_yellow_o <= 1'b0;
                    ns_green_o  <= 1'b0;
                    ew_red_o    <= 1'b1;
                    ew_yellow_o <= 1'b0;
                    ew_green_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed-vector bench for traffic_conflict_monitor.
// Each observation is packed as {fault, fault_code, ns r/y/g, ew r/y/g}.
module tb_traffic_conflict_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;

    logic       clk;
    logic       rst_n;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       clear;
    logic       ns_red_o, ns_yellow_o, ns_green_o;
    logic       ew_red_o, ew_yellow_o, ew_green_o;
    logic       fault;
    logic [2:0] fault_code;

    int errors;
    int checks;

    traffic_conflict_monitor #(
        .MIN_YELLOW(3),
        .FAULT_PERSIST(2),
        .FLASH_HALF(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ns_red(ns_red),
        .ns_yellow(ns_yellow),
        .ns_green(ns_green),
        .ew_red(ew_red),
        .ew_yellow(ew_yellow),
        .ew_green(ew_green),
        .clear(clear),
        .ns_red_o(ns_red_o),
        .ns_yellow_o(ns_yellow_o),
        .ns_green_o(ns_green_o),
        .ew_red_o(ew_red_o),
        .ew_yellow_o(ew_yellow_o),
        .ew_green_o(ew_green_o),
        .fault(fault),
        .fault_code(fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [9:0] expect_word(input logic f, input logic [2:0] code,
                                               input logic [2:0] ns, input logic [2:0] ew);
        return {f, code, ns, ew};
    endfunction

    function automatic logic [9:0] observed();
        return {fault, fault_code, ns_red_o, ns_yellow_o, ns_green_o,
                ew_red_o, ew_yellow_o, ew_green_o};
    endfunction

    task automatic checkOutput(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed=%b expected=%b (fault,code,ns_ryg,ew_ryg)", tag, obs, exp);
        end
    endtask

    // Drive one input vector, clock it in, and leave time just past the edge for sampling.
    task automatic applyStimulus(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
        {ns_red, ns_yellow, ns_green} = ns;
        {ew_red, ew_yellow, ew_green} = ew;
        clear = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic passPhase(input string tag, input logic [2:0] ns, input logic [2:0] ew, input int len);
        for (int k = 0; k < len; k++) begin
            applyStimulus(ns, ew, 1'b0);
            checkOutput(tag, observed(), expect_word(1'b0, 3'd0, ns, ew));
        end
    endtask

    initial begin
        logic red_on;
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        clear  = 1'b0;
        {ns_red, ns_yellow, ns_green} = G;
        {ew_red, ew_yellow, ew_green} = G;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_async", observed(), expect_word(1'b0, 3'd0, R, R));
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_held", observed(), expect_word(1'b0, 3'd0, R, R));
        rst_n = 1'b1;

        for (int rnd = 0; rnd < 3; rnd++) begin
            passPhase("normal_ns_green", G, R, 11);
            passPhase("normal_ns_yellow", Y, R, 4);
            passPhase("normal_ew_green", R, G, 11);
            passPhase("normal_ew_yellow", R, Y, 4);
        end

        applyStimulus(G, G, 1'b0);
        checkOutput("glitch_allred", observed(), expect_word(1'b0, 3'd0, R, R));
        applyStimulus(R, R, 1'b0);
        checkOutput("glitch_resume", observed(), expect_word(1'b0, 3'd0, R, R));
        passPhase("glitch_after", G, R, 2);

        applyStimulus(G, G, 1'b0);
        checkOutput("persist_suspect", observed(), expect_word(1'b0, 3'd0, R, R));
        applyStimulus(G, G, 1'b0);
        checkOutput("persist_fault_entry", observed(), expect_word(1'b1, 3'd1, R, R));
        for (int i = 1; i < 15; i++) begin
            applyStimulus(G, G, 1'b0);
            red_on = ((i / 5) % 2) == 0;
            checkOutput("persist_flash", observed(),
                        expect_word(1'b1, 3'd1, red_on ? R : D, red_on ? R : D));
        end

        applyStimulus(G, G, 1'b1);
        checkOutput("clear_illegal_ignored", observed(), expect_word(1'b1, 3'd1, D, D));
        applyStimulus(G, R, 1'b1);
        checkOutput("clear_recover", observed(), expect_word(1'b0, 3'd0, G, R));
        applyStimulus(R, R, 1'b0);
        checkOutput("recover_no_seq", observed(), expect_word(1'b0, 3'd0, R, R));

        passPhase("shorty_green", G, R, 2);
        passPhase("shorty_yellow", Y, R, 2);
        applyStimulus(R, R, 1'b0);
        checkOutput("short_yellow_fault", observed(), expect_word(1'b1, 3'd4, R, R));

        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
        applyStimulus(G, R, 1'b0);
        checkOutput("seq_after_reset", observed(), expect_word(1'b0, 3'd0, G, R));
        applyStimulus(R, R, 1'b0);
        checkOutput("seq_fault", observed(), expect_word(1'b1, 3'd3, R, R));

        applyStimulus(R, R, 1'b1);
        checkOutput("seq_clear", observed(), expect_word(1'b0, 3'd0, R, R));
        applyStimulus(D, R, 1'b0);
        checkOutput("lamp_suspect", observed(), expect_word(1'b0, 3'd0, R, R));
        applyStimulus(D, R, 1'b0);
        checkOutput("lamp_fault", observed(), expect_word(1'b1, 3'd2, R, R));
        for (int i = 1; i < 6; i++) begin
            applyStimulus(D, R, 1'b0);
        end
        checkOutput("lamp_flash_off", observed(), expect_word(1'b1, 3'd2, D, D));

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_flash", observed(), expect_word(1'b0, 3'd0, R, R));
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(G, R, 1'b0);
        checkOutput("post_reset_pass", observed(), expect_word(1'b0, 3'd0, G, R));
        applyStimulus(Y, R, 1'b0);
        checkOutput("post_reset_yellow", observed(), expect_word(1'b0, 3'd0, Y, R));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
